// File: rtl/uap_cmd_ctrl.sv
// UART probe command sequencer: decodes fixed-format byte commands, drives GPO
// and a single-outstanding bus master port, and streams response bytes back.
module uap_cmd_ctrl #(
  parameter int GPO_W       = 32,
  parameter int GPI_W       = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic [GPO_W-1:0] gpo,
  input  logic [GPI_W-1:0] gpi,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_err,
  output logic [1:0]       err_flags
);

  typedef enum logic [2:0] {IDLE, ARG, EXEC, BUS, RSP} state_t;

  localparam logic [7:0] OP_GPO_WR = 8'h01;
  localparam logic [7:0] OP_GPI_RD = 8'h02;
  localparam logic [7:0] OP_MEM_RD = 8'h03;
  localparam logic [7:0] OP_MEM_WR = 8'h04;

  state_t      state;
  logic [7:0]  opcode;
  logic [63:0] arg_sr;   // argument bytes shifted in MSB first
  logic [3:0]  arg_cnt;  // argument bytes still expected
  logic [31:0] tmo_cnt;
  logic [39:0] rsp_buf;  // pending response bytes, next byte in [39:32]
  logic [2:0]  rsp_cnt;  // bytes left in rsp_buf after the one on tx_data

  // NOTE: every register here is state, so all updates are non-blocking; a
  // blocking write would let later statements in the same edge see the new value.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      opcode    <= 8'h00;
      arg_sr    <= 64'h0;
      arg_cnt   <= 4'd0;
      tmo_cnt   <= 32'd0;
      rsp_buf   <= 40'h0;
      rsp_cnt   <= 3'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      gpo       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      err_flags <= 2'b00;
    end else begin
      // No input buffering: bytes arriving while a command executes are lost.
      if (rx_valid && (state == EXEC || state == BUS || state == RSP))
        err_flags[0] <= 1'b1;

      // NOTE: the default arm keeps the decode complete for every encoding.
      case (state)
        IDLE: begin
          if (rx_valid) begin
            opcode  <= rx_data;
            tmo_cnt <= 32'd0;
            case (rx_data)
              OP_GPO_WR, OP_MEM_RD: begin
                arg_cnt <= 4'd4;
                state   <= ARG;
              end
              OP_MEM_WR: begin
                arg_cnt <= 4'd8;
                state   <= ARG;
              end
              OP_GPI_RD: begin
                rsp_buf <= {32'(gpi), 8'h00};
                rsp_cnt <= 3'd5;
                state   <= RSP;
              end
              default: begin
                rsp_buf <= {8'hFF, 32'h0};
                rsp_cnt <= 3'd1;
                state   <= RSP;
              end
            endcase
          end
        end

        ARG: begin
          if (rx_valid) begin
            arg_sr  <= {arg_sr[55:0], rx_data};
            arg_cnt <= arg_cnt - 4'd1;
            tmo_cnt <= 32'd0;
            if (arg_cnt == 4'd1) state <= EXEC;
          end else if (tmo_cnt >= 32'(TIMEOUT_CYC - 1)) begin
            err_flags[1] <= 1'b1;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        EXEC: begin
          if (opcode == OP_GPO_WR) begin
            gpo     <= arg_sr[GPO_W-1:0];
            rsp_buf <= {8'h00, 32'h0};
            rsp_cnt <= 3'd1;
            state   <= RSP;
          end else begin
            // MEM_WR carries address then data; MEM_RD only an address.
            mem_req   <= 1'b1;
            mem_we    <= (opcode == OP_MEM_WR);
            mem_addr  <= (opcode == OP_MEM_WR) ? arg_sr[63:32] : arg_sr[31:0];
            mem_wdata <= (opcode == OP_MEM_WR) ? arg_sr[31:0] : 32'h0;
            state     <= BUS;
          end
        end

        BUS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RSP;
            if (mem_we) begin
              rsp_buf <= {7'b0, mem_err, 32'h0};
              rsp_cnt <= 3'd1;
            end else begin
              rsp_buf <= {(mem_err ? 32'h0 : mem_rdata), 7'b0, mem_err};
              rsp_cnt <= 3'd5;
            end
          end
        end

        RSP: begin
          if (!tx_valid || tx_ready) begin
            if (tx_valid && rsp_cnt == 3'd0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= rsp_buf[39:32];
              rsp_buf  <= {rsp_buf[31:0], 8'h00};
              rsp_cnt  <= rsp_cnt - 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uap_cmd_ctrl.md
Name: uap_cmd_ctrl

Overview:
- Command sequencer for the UART probe. Consumes received UART bytes, decodes fixed-format commands, and drives the GPO register and a single-outstanding bus-master request port.
- Returns response bytes to the UART transmitter.
- Sits between the UART RX/TX byte engines and the AXI master / GPIO logic inside the probe top level.

Parameters:
- GPO_W, 32, GPO width (1..32); low GPO_W bits of the assembled 32-bit word are used.
- GPI_W, 32, GPI width (1..32); zero-extended to 32 bits for readback.
- TIMEOUT_CYC, 1000000, max idle cycles between argument bytes before a command is abandoned.

Ports:
- clk  in  1  system clock
- aresetn  in  1  reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  response byte valid
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
- tx_data  out  8  response byte
- gpo  out  GPO_W  general purpose outputs
- gpi  in  GPI_W  general purpose inputs
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1=write, 0=read; stable while mem_req
- mem_addr  out  32  bus address; stable while mem_req
- mem_wdata  out  32  write data; stable while mem_req
- mem_ack  in  1  one-cycle completion strobe
- mem_rdata  in  32  read data, valid with mem_ack
- mem_err  in  1  bus error, valid with mem_ack
- err_flags  out  2  sticky: [0] rx byte dropped, [1] argument timeout

Behaviour:
- Reset is asynchronous, active-low; single clock domain. Reset values: gpo=0, tx_valid=0, tx_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err_flags=0, FSM=IDLE.
- Reset mid-command aborts everything: no partial response, and gpo returns to 0.
- Opcodes: 0x01 GPO_WR (4 arg bytes), 0x02 GPI_RD (0 args), 0x03 MEM_RD (4 addr bytes), 0x04 MEM_WR (4 addr + 4 data bytes).
- Multi-byte fields are sent MSB first.
- Status byte values: 0x00 OK, 0x01 bus error, 0xFF bad opcode.
- FSM states: IDLE -> ARG -> (EXEC | BUS) -> RSP -> IDLE.
- IDLE:
  - rx_valid with a known opcode latches the opcode. GPI_RD also snapshots gpi in the same cycle and goes straight to RSP.
  - Any other opcode goes to RSP with the single byte 0xFF.
- ARG:
  - Shifts bytes into addr/data registers; a byte counter tracks the expected count.
  - The timeout counter clears on every accepted byte.
  - If TIMEOUT_CYC cycles pass with no byte: go to IDLE with no response and set err_flags[1].
- After the last argument byte is accepted in cycle N:
  - GPO_WR: gpo updates at edge N+1; RSP sends 0x00.
  - MEM_RD / MEM_WR: mem_req rises at N+1 with addr/we/wdata stable (BUS state).
- BUS:
  - On mem_ack, mem_req falls the next cycle and the response is built.
  - MEM_RD: 4 rdata bytes then status. Data bytes are 0x00 if mem_err.
  - MEM_WR: status only.
  - No timeout applies in BUS.
  - mem_ack outside BUS is ignored.
- RSP:
  - tx_valid asserts the cycle after entering RSP.
  - tx_data is held stable until tx_valid&tx_ready. The next byte is presented the following cycle; tx_valid may stay high across bytes.
  - After the last byte handshakes, tx_valid=0 and the FSM returns to IDLE.
- Response lengths: GPO_WR 1, GPI_RD 5, MEM_RD 5, MEM_WR 1, bad opcode 1.
- rx_valid in BUS or RSP: the byte is dropped and err_flags[0] is set. rx_valid in the same cycle the FSM returns to IDLE is also dropped.
- Only one command is in flight at a time; there is no input buffering.
- err_flags clear only on reset.

Test Plan:
- Bytes 01 12 34 56 78 -> gpo=0x12345678 one cycle after the last byte; tx emits 00; mem_req stays 0.
- gpi=0xCAFEF00D, byte 02, tx_ready held 1 -> tx emits CA FE F0 0D 00, one byte per cycle.
- Bytes 03 00 00 10 00; model acks 3 cycles later with rdata=0xDEADBEEF, err=0 -> mem_req held 3 cycles, mem_we=0, mem_addr=0x1000; tx emits DE AD BE EF 00.
- Bytes 04 00 00 00 04 A5 A5 A5 A5; ack with err=1 -> mem_we=1, mem_wdata=0xA5A5A5A5; tx emits 01.
- Byte 7F -> tx emits FF; then bytes 01 AA and silence for TIMEOUT_CYC (set to 16) cycles -> return to IDLE with no tx, err_flags=2'b10, gpo unchanged.
- During a MEM_RD BUS wait, inject rx byte 55 -> err_flags[0]=1 and the response is unaffected. Deassert aresetn mid-RSP -> tx_valid=0 and gpo=0 immediately.
